shared_vc_bank_ctrl: RTL

//  Ownership and occupancy controller for the router's shared VC buffer bank (shared_vc / memory_bank_grant path).

---
 rtl/shared_vc_bank_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/shared_vc_bank_ctrl.sv
// Shared VC buffer bank controller: round-robin ownership with bounded hold and a
// one-cycle release gap, plus flit occupancy tracking with a sticky protocol error.
module shared_vc_bank_ctrl #(
  parameter int num_ports          = 5,
  parameter int shared_buffer_size = 8,
  parameter int max_hold           = 16,
  parameter int port_idx_width     = (num_ports > 1) ? $clog2(num_ports) : 1,
  parameter int cnt_width          = $clog2(shared_buffer_size + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [num_ports-1:0]      req_ip,
  input  logic [num_ports-1:0]      alloc_ip,
  input  logic                      free_in,
  output logic [num_ports-1:0]      grant_op,
  output logic [port_idx_width-1:0] owner_idx,
  output logic [cnt_width-1:0]      bank_count,
  output logic                      bank_full,
  output logic                      bank_empty,
  output logic                      error
);

  localparam int hold_width = (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  localparam int preempt_at = (max_hold > 0) ? max_hold - 1 : 0;

  localparam logic [1:0] st_idle  = 2'd0;
  localparam logic [1:0] st_owned = 2'd1;
  localparam logic [1:0] st_turn  = 2'd2;

  logic [1:0]                state_reg, state_next;
  logic [num_ports-1:0]      grant_reg, grant_next;
  logic [port_idx_width-1:0] owner_reg, owner_next;
  logic [port_idx_width-1:0] ptr_reg, ptr_next;
  logic [hold_width-1:0]     hold_reg, hold_next;
  logic [cnt_width-1:0]      count_reg, count_next;
  logic                      full_reg, empty_reg, error_reg;

  // Candidate k is the port k places after the round-robin pointer.
  logic [port_idx_width-1:0] cand_idx [num_ports];
  logic [num_ports-1:0]      cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < num_ports; gi++) begin : g_cand
      logic [port_idx_width:0] sum_w;
      assign sum_w = {1'b0, ptr_reg} + (port_idx_width + 1)'(gi);
      assign cand_idx[gi] = (sum_w >= (port_idx_width + 1)'(num_ports))
                            ? port_idx_width'(sum_w - (port_idx_width + 1)'(num_ports))
                            : port_idx_width'(sum_w);
      assign cand_req[gi] = req_ip[cand_idx[gi]];
    end
  endgenerate

  logic                      winner_found;
  logic [port_idx_width-1:0] winner_idx;

  // Scan from the far end so the candidate closest to the pointer wins.
  always_comb begin
    winner_found = 1'b0;
    winner_idx   = '0;
    for (int k = num_ports - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        winner_found = 1'b1;
        winner_idx   = cand_idx[k];
      end
    end
  end

  logic preempt;
  assign preempt = (max_hold > 0) && (hold_reg == hold_width'(preempt_at))
                   && |(req_ip & ~grant_reg);

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
    hold_next  = hold_reg;
    case (state_reg)
      st_owned: begin
        if (!req_ip[owner_reg] || preempt) begin
          state_next = st_turn;
          grant_next = '0;
        end else if (hold_reg != hold_width'(max_hold)) begin
          hold_next = hold_reg + 1'b1;
        end
      end
      default: begin
        if (winner_found) begin
          state_next = st_owned;
          grant_next = num_ports'(1) << winner_idx;
          owner_next = winner_idx;
          ptr_next   = (winner_idx == port_idx_width'(num_ports - 1)) ? '0 : winner_idx + 1'b1;
          hold_next  = '0;
        end else begin
          state_next = st_idle;
        end
      end
    endcase
  end

  // Only a single alloc bit matching the current grant is a legal owner write.
  logic owner_alloc, bad_alloc, acc_alloc, acc_free, err_event;
  assign owner_alloc = (state_reg == st_owned) && (alloc_ip == grant_reg);
  assign bad_alloc   = (alloc_ip != '0) && !owner_alloc;
  assign acc_alloc   = owner_alloc && !full_reg;
  assign acc_free    = free_in && !empty_reg;
  assign err_event   = bad_alloc || (owner_alloc && full_reg) || (free_in && empty_reg);

  always_comb begin
    count_next = count_reg;
    if (acc_alloc && !acc_free) count_next = count_reg + 1'b1;
    else if (!acc_alloc && acc_free) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= st_idle;
      grant_reg <= '0;
      owner_reg <= '0;
      ptr_reg   <= '0;
      hold_reg  <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      error_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
      hold_reg  <= hold_next;
      count_reg <= count_next;
      full_reg  <= (count_next == cnt_width'(shared_buffer_size));
      empty_reg <= (count_next == '0);
      error_reg <= error_reg | err_event;
    end
  end

  assign grant_op   = grant_reg;
  assign owner_idx  = owner_reg;
  assign bank_count = count_reg;
  assign bank_full  = full_reg;
  assign bank_empty = empty_reg;
  assign error      = error_reg;

endmodule
